// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared states, BCD digit limits and character codes for the alarm/clock blocks
package clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWD,
    ST_ENTRY,
    ST_OK,
    ST_ERR,
    ST_TMO,
    ST_EDIT
`ifdef ALARM_LOCKOUT_EN
    , ST_LOCK
`endif
  } state_t;

  typedef enum logic {
    STEP_ENTRY,
    STEP_EDIT
  } step_mode_t;

  localparam logic [3:0] MAX_UNITS         = 4'd9;
  localparam logic [3:0] MAX_MIN_TENS      = 4'd5;
  localparam logic [3:0] MAX_HOUR_TENS     = 4'd2;
  localparam logic [3:0] MAX_HOUR_UNITS_20 = 4'd3;

  // Character codes above the decimal digits, as understood by the display decoder
  localparam logic [4:0] CH_BLANK = 5'h10;
  localparam logic [4:0] CH_P     = 5'h11;
  localparam logic [4:0] CH_A     = 5'h12;
  localparam logic [4:0] CH_S     = 5'h13;
  localparam logic [4:0] CH_O     = 5'h14;
  localparam logic [4:0] CH_K     = 5'h15;
  localparam logic [4:0] CH_E     = 5'h16;
  localparam logic [4:0] CH_R     = 5'h17;
  localparam logic [4:0] CH_T     = 5'h18;

endpackage

// File: rtl/bcd_digit_step.sv
// rtl/bcd_digit_step.sv - next value of the digit under the cursor, with HH:MM limits in edit mode
module bcd_digit_step
  import clock_pkg::*;
(
  input  logic [1:0] idx,
  input  logic [3:0] cur,
  input  logic [3:0] d3,
  input  step_mode_t mode,
  output logic [3:0] nxt,
  output logic       clamp_d2
);

  logic [3:0] max_val;

  always_comb begin
    max_val = MAX_UNITS;
    if (mode == STEP_EDIT) begin
      case (idx)
        2'd1:    max_val = MAX_MIN_TENS;
        2'd2:    max_val = (d3 == MAX_HOUR_TENS) ? MAX_HOUR_UNITS_20 : MAX_UNITS;
        2'd3:    max_val = MAX_HOUR_TENS;
        default: max_val = MAX_UNITS;
      endcase
    end
    nxt = (cur >= max_val) ? 4'd0 : cur + 4'd1;
    // Hour tens stepping onto 2 may leave an illegal hour units digit behind
    clamp_d2 = (mode == STEP_EDIT) && (idx == 2'd3) && (nxt == MAX_HOUR_TENS);
  end

endmodule

// File: rtl/alarm_access_ctrl.sv
// rtl/alarm_access_ctrl.sv - PIN-gated alarm editor feeding the seven-segment driver; ALARM_LOCKOUT_EN adds wrong-PIN lockout
module alarm_access_ctrl
  import clock_pkg::*;
#(
  parameter logic [15:0] PIN       = 16'h1234,
  parameter int          BANNER_S  = 2,
  parameter int          TIMEOUT_S = 10
`ifdef ALARM_LOCKOUT_EN
  , parameter int        MAX_TRIES = 3,
  parameter int          LOCKOUT_S = 30
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_enter,
  output logic       alarm_mode,
  output logic [1:0] cursor_pos,
  output logic [3:0] alarm_d0,
  output logic [3:0] alarm_d1,
  output logic [3:0] alarm_d2,
  output logic [3:0] alarm_d3,
  output logic       show_pwd,
  output logic       show_ok,
  output logic       show_err,
  output logic       show_tmo,
  output logic [3:0] alm_d0,
  output logic [3:0] alm_d1,
  output logic [3:0] alm_d2,
  output logic [3:0] alm_d3,
  output logic       alarm_saved
);

  localparam int BASE_MAX = (TIMEOUT_S > BANNER_S) ? TIMEOUT_S : BANNER_S;
`ifdef ALARM_LOCKOUT_EN
  localparam int CNT_MAX  = (LOCKOUT_S > BASE_MAX) ? LOCKOUT_S : BASE_MAX;
  localparam int TRY_W    = $clog2(MAX_TRIES + 1);
`else
  localparam int CNT_MAX  = BASE_MAX;
`endif
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  sec_cnt, sec_cnt_n;
  logic [3:0][3:0]   digits, digits_n;
  logic [1:0]        cursor, cursor_n;
  logic [3:0][3:0]   alm, alm_n;
  logic              saved_n;
  logic [3:0]        step_nxt;
  logic              step_clamp;
  logic              any_btn;
  logic              banner_done;
  logic              editing;
`ifdef ALARM_LOCKOUT_EN
  logic [TRY_W-1:0]  tries, tries_n;
`endif

  bcd_digit_step u_step (
    .idx      (cursor),
    .cur      (digits[cursor]),
    .d3       (digits[3]),
    .mode     ((state == ST_EDIT) ? STEP_EDIT : STEP_ENTRY),
    .nxt      (step_nxt),
    .clamp_d2 (step_clamp)
  );

  assign any_btn     = btn_mode | btn_next | btn_inc | btn_enter;
  assign banner_done = tick_1s && (sec_cnt == CNT_W'(BANNER_S - 1));
  assign editing     = (state == ST_ENTRY) || (state == ST_EDIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      sec_cnt     <= '0;
      digits      <= '0;
      cursor      <= 2'd0;
      alm         <= '0;
      alarm_saved <= 1'b0;
`ifdef ALARM_LOCKOUT_EN
      tries       <= '0;
`endif
    end else begin
      state       <= state_n;
      sec_cnt     <= sec_cnt_n;
      digits      <= digits_n;
      cursor      <= cursor_n;
      alm         <= alm_n;
      alarm_saved <= saved_n;
`ifdef ALARM_LOCKOUT_EN
      tries       <= tries_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    digits_n = digits;
    cursor_n = cursor;
    alm_n    = alm;
    saved_n  = 1'b0;
`ifdef ALARM_LOCKOUT_EN
    tries_n  = tries;
`endif
    case (state)
      ST_IDLE: if (btn_mode) state_n = ST_PWD;
      ST_PWD: begin
        if (banner_done) begin
          state_n  = ST_ENTRY;
          digits_n = '0;
          cursor_n = 2'd3;
        end
      end
      ST_ENTRY, ST_EDIT: begin
        if (btn_mode) begin
          state_n = ST_IDLE;
        end else if (btn_enter) begin
          if (state == ST_EDIT) begin
            alm_n   = digits;
            saved_n = 1'b1;
            state_n = ST_IDLE;
          end else if (digits == PIN) begin
            state_n = ST_OK;
`ifdef ALARM_LOCKOUT_EN
            tries_n = '0;
`endif
          end else begin
            state_n = ST_ERR;
`ifdef ALARM_LOCKOUT_EN
            if (tries < TRY_W'(MAX_TRIES)) tries_n = tries + TRY_W'(1);
`endif
          end
        end else if (btn_next) begin
          cursor_n = cursor - 2'd1;
        end else if (btn_inc) begin
          digits_n[cursor] = step_nxt;
          if (step_clamp && (digits[2] > MAX_HOUR_UNITS_20)) digits_n[2] = MAX_HOUR_UNITS_20;
        end else if (tick_1s && (sec_cnt == CNT_W'(TIMEOUT_S - 1))) begin
          state_n = ST_TMO;
        end
      end
      ST_OK: begin
        if (banner_done) begin
          state_n  = ST_EDIT;
          digits_n = alm;
          cursor_n = 2'd3;
        end
      end
      ST_ERR: begin
        if (banner_done) begin
`ifdef ALARM_LOCKOUT_EN
          state_n = (tries >= TRY_W'(MAX_TRIES)) ? ST_LOCK : ST_IDLE;
`else
          state_n = ST_IDLE;
`endif
        end
      end
      ST_TMO: if (banner_done) state_n = ST_IDLE;
`ifdef ALARM_LOCKOUT_EN
      ST_LOCK: begin
        if (tick_1s && (sec_cnt == CNT_W'(LOCKOUT_S - 1))) begin
          state_n = ST_IDLE;
          tries_n = '0;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase

    // A button in the interactive states restarts the idle count and swallows a coincident tick
    sec_cnt_n = sec_cnt;
    if (state_n != state || state == ST_IDLE) sec_cnt_n = '0;
    else if (editing && any_btn)              sec_cnt_n = '0;
    else if (tick_1s)                         sec_cnt_n = sec_cnt + CNT_W'(1);
  end

  always_comb begin
    alarm_mode = editing;
    cursor_pos = editing ? cursor : 2'd0;
    alarm_d0   = editing ? digits[0] : 4'd0;
    alarm_d1   = editing ? digits[1] : 4'd0;
    alarm_d2   = editing ? digits[2] : 4'd0;
    alarm_d3   = editing ? digits[3] : 4'd0;
    show_pwd   = (state == ST_PWD);
    show_ok    = (state == ST_OK);
    show_tmo   = (state == ST_TMO);
`ifdef ALARM_LOCKOUT_EN
    show_err   = (state == ST_ERR) || (state == ST_LOCK);
`else
    show_err   = (state == ST_ERR);
`endif
  end

  assign alm_d0 = alm[0];
  assign alm_d1 = alm[1];
  assign alm_d2 = alm[2];
  assign alm_d3 = alm[3];

endmodule
